ita_tile_streamer: RTL and testbench

- Memory-to-stream transmitter for the accelerator's input-side valid/ready streams (activation input, weight or bias).
- Walks a 2-D tile of N-element vectors in memory using a row/column stride address generator.
- Issues in-order read requests, buffers the returned data in a credit-limited FIFO, and presents one vector per handshake on a valid/ready master port.
- Instantiated once per ITA input stream in the cluster wrapper.

---
 rtl/ita_tile_streamer_if.sv | 26 ++
 rtl/ita_tile_streamer.sv | 180 ++++++++++++++++++
 tb/tb_ita_tile_streamer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ita_tile_streamer_if.sv
// Memory read port and vector stream port of the ITA tile streamer.
// The master modport is the streamer side; the slave modport is memory plus stream sink.
interface ita_tile_streamer_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned WI = 8,
  parameter int unsigned AW = 32
);
  logic            mem_req;
  logic            mem_gnt;
  logic [AW-1:0]   mem_addr;
  logic            mem_rvalid;
  logic [N*WI-1:0] mem_rdata;
  logic            valid;
  logic            ready;
  logic [N*WI-1:0] data;

  modport master (
    output mem_req, mem_addr, valid, data,
    input  mem_gnt, mem_rvalid, mem_rdata, ready
  );

  modport slave (
    input  mem_req, mem_addr, valid, data,
    output mem_gnt, mem_rvalid, mem_rdata, ready
  );
endinterface

// File: rtl/ita_tile_streamer.sv
// Walks a 2-D tile of vectors in memory and streams them out through a credit-limited FIFO.
// Optional zero padding after each row is enabled with ITA_TILE_STREAMER_ZERO_PAD_EN.
module ita_tile_streamer #(
  parameter int unsigned N     = 16,
  parameter int unsigned WI    = 8,
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [CW-1:0] num_rows_i,
  input  logic [CW-1:0] num_cols_i,
  input  logic [CW-1:0] row_stride_i,
  input  logic [CW-1:0] col_stride_i,
`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
  input  logic [CW-1:0] pad_cols_i,
`endif
  output logic          busy_o,
  output logic          done_o,
  ita_tile_streamer_if.master bus
);

  localparam int unsigned DW   = N * WI;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH + 1);
  localparam logic [CNTW:0] CREDITS = (CNTW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, FIN} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]   rows_q, cols_q, row_stride_q, col_stride_q;
  logic [CW-1:0]   row_idx_q, col_idx_q;
  logic [AW-1:0]   row_base_q, addr_q;
  logic [CNTW-1:0] out_q, out_d;
  logic [CNTW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [DW-1:0]   fifo_mem [DEPTH];

  logic credit_ok, gnt_fire, rsp_fire, push, pop, fifo_valid;
  logic last_col, last_row, row_end, tile_end, empty_tile;
  logic [DW-1:0] push_data;

  assign credit_ok  = ({1'b0, out_q} + {1'b0, fifo_cnt_q}) < CREDITS;
  assign gnt_fire   = bus.mem_req && bus.mem_gnt;
  // Responses with nothing outstanding are leftovers from an aborted transfer.
  assign rsp_fire   = bus.mem_rvalid && (out_q != '0);
  assign fifo_valid = (fifo_cnt_q != '0);
  assign pop        = fifo_valid && bus.ready;
  assign last_col   = (col_idx_q == cols_q - CW'(1));
  assign last_row   = (row_idx_q == rows_q - CW'(1));
  assign tile_end   = row_end && last_row;

`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
  logic          in_pad_q, pad_push, last_pad;
  logic [CW-1:0] pad_cols_q, pad_idx_q;

  // Pads wait for every outstanding read so they land behind the row's data.
  assign pad_push    = (state_q == REQ) && in_pad_q && credit_ok && (out_q == '0);
  assign last_pad    = (pad_idx_q == pad_cols_q - CW'(1));
  assign bus.mem_req = (state_q == REQ) && !in_pad_q && credit_ok;
  assign row_end     = (gnt_fire && last_col && (pad_cols_q == '0)) || (pad_push && last_pad);
  assign empty_tile  = (num_rows_i == '0) || ((num_cols_i == '0) && (pad_cols_i == '0));
  assign push        = rsp_fire || pad_push;
  assign push_data   = pad_push ? '0 : bus.mem_rdata;
`else
  assign bus.mem_req = (state_q == REQ) && credit_ok;
  assign row_end     = gnt_fire && last_col;
  assign empty_tile  = (num_rows_i == '0) || (num_cols_i == '0);
  assign push        = rsp_fire;
  assign push_data   = bus.mem_rdata;
`endif

  assign out_d      = out_q + CNTW'(gnt_fire) - CNTW'(rsp_fire);
  assign fifo_cnt_d = fifo_cnt_q + CNTW'(push) - CNTW'(pop);

  assign bus.mem_addr = addr_q;
  assign bus.valid    = fifo_valid;
  assign bus.data     = fifo_valid ? fifo_mem[rptr_q] : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, otherwise a missed branch infers a latch.
  always_comb begin
    state_d = state_q;
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == FIN);
    unique case (state_q)
      IDLE:    if (start_i) state_d = empty_tile ? FIN : REQ;
      REQ:     if (tile_end) state_d = DRAIN;
      // Look at next-cycle counts so done follows the final handshake directly.
      DRAIN:   if ((out_d == '0) && (fifo_cnt_d == '0)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rows_q       <= '0;
      cols_q       <= '0;
      row_stride_q <= '0;
      col_stride_q <= '0;
      row_idx_q    <= '0;
      col_idx_q    <= '0;
      row_base_q   <= '0;
      addr_q       <= '0;
      out_q        <= '0;
      fifo_cnt_q   <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
      in_pad_q     <= 1'b0;
      pad_cols_q   <= '0;
      pad_idx_q    <= '0;
`endif
    end else begin
      out_q      <= out_d;
      fifo_cnt_q <= fifo_cnt_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);

      if (state_q == IDLE) begin
        if (start_i) begin
          rows_q       <= num_rows_i;
          cols_q       <= num_cols_i;
          row_stride_q <= row_stride_i;
          col_stride_q <= col_stride_i;
          row_idx_q    <= '0;
          col_idx_q    <= '0;
          row_base_q   <= base_addr_i;
          addr_q       <= base_addr_i;
`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
          pad_cols_q   <= pad_cols_i;
          pad_idx_q    <= '0;
          in_pad_q     <= (num_cols_i == '0);
`endif
        end
      end else if (state_q == REQ) begin
        // Incremental address walk: row base steps by row stride, column by column stride.
        if (row_end && !last_row) begin
          row_idx_q  <= row_idx_q + CW'(1);
          col_idx_q  <= '0;
          row_base_q <= row_base_q + AW'(row_stride_q);
          addr_q     <= row_base_q + AW'(row_stride_q);
`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
          in_pad_q   <= (cols_q == '0);
          pad_idx_q  <= '0;
`endif
        end else if (gnt_fire && !last_col) begin
          col_idx_q <= col_idx_q + CW'(1);
          addr_q    <= addr_q + AW'(col_stride_q);
`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
        end else if (gnt_fire && (pad_cols_q != '0)) begin
          in_pad_q  <= 1'b1;
          pad_idx_q <= '0;
        end else if (pad_push) begin
          pad_idx_q <= pad_idx_q + CW'(1);
`endif
        end
      end
    end
  end

  // NOTE: FIFO storage has no reset; data_o is masked by valid_o so stale entries never leak.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (fifo_cnt_q == CNTW'(DEPTH))));

endmodule

// File: tb/tb_ita_tile_streamer.sv
// Self-checking bench for ita_tile_streamer: memory model with programmable latency and grant
// stalls, stream sink with backpressure, and an expected address/data scoreboard.
module tb_ita_tile_streamer;
  localparam int unsigned N = 16, WI = 8, AW = 32, DEPTH = 4, CW = 16;
  localparam int unsigned DW = N * WI;

  logic clk_i = 1'b0;
  logic rst_i, start_i, busy_o, done_o;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] num_rows, num_cols, row_stride, col_stride;
`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
  logic [CW-1:0] pad_cols;
`endif

  ita_tile_streamer_if #(.N(N), .WI(WI), .AW(AW)) bus ();

  ita_tile_streamer #(.N(N), .WI(WI), .AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .base_addr_i  (base_addr),
    .num_rows_i   (num_rows),
    .num_cols_i   (num_cols),
    .row_stride_i (row_stride),
    .col_stride_i (col_stride),
`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
    .pad_cols_i   (pad_cols),
`endif
    .busy_o       (busy_o),
    .done_o       (done_o),
    .bus          (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] a;
    int            due;
  } rsp_t;

  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  rsp_t          rsp_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, lat = 1;
  logic gnt_en = 1'b1, rdy_en = 1'b1;
  int n_grant = 0, n_hs = 0, n_rvalid = 0, n_vld = 0, done_cnt = 0;
  int first_gnt_cyc = -1, first_vld_cyc = -1, last_hs_cyc = -1, done_cyc = -1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'hA5A5_5A5A, a + 32'd7};
  endfunction

  // Memory and sink model: drive inputs at negedge+1, sample handshakes at negedge+2.
  always @(negedge clk_i) begin
    #1;
    cyc++;
    bus.mem_gnt = gnt_en;
    bus.ready   = rdy_en;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = mem_fn(rsp_q[0].a);
      void'(rsp_q.pop_front());
      n_rvalid++;
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end
    #1;
    if (bus.mem_req && bus.mem_gnt) begin
      n_grant++;
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
      if (exp_addr.size() == 0) check("extra_grant", DW'(exp_addr.size()), 1);
      else check("grant_addr", DW'(bus.mem_addr), DW'(exp_addr.pop_front()));
      rsp_q.push_back('{a: bus.mem_addr, due: cyc + lat});
    end
    if (bus.valid) begin
      n_vld++;
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
    end
    if (bus.valid && bus.ready) begin
      n_hs++;
      last_hs_cyc = cyc;
      if (exp_data.size() == 0) check("extra_vector", DW'(exp_data.size()), 1);
      else check("stream_data", bus.data, exp_data.pop_front());
    end
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic run_tile(input logic [AW-1:0] base, input logic [CW-1:0] rows, input logic [CW-1:0] cols,
                          input logic [CW-1:0] rs, input logic [CW-1:0] cs, input logic [CW-1:0] pad);
    logic [AW-1:0] a;
    exp_addr.delete();
    exp_data.delete();
    for (int r = 0; r < int'(rows); r++) begin
      for (int c = 0; c < int'(cols); c++) begin
        a = base + AW'(r) * AW'(rs) + AW'(c) * AW'(cs);
        exp_addr.push_back(a);
        exp_data.push_back(mem_fn(a));
      end
`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
      for (int p = 0; p < int'(pad); p++) exp_data.push_back('0);
`endif
    end
    n_grant = 0; n_hs = 0; done_cnt = 0;
    first_gnt_cyc = -1; first_vld_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
    @(negedge clk_i);
    base_addr = base; num_rows = rows; num_cols = cols; row_stride = rs; col_stride = cs;
`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
    pad_cols = pad;
`endif
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    // Scramble configuration: it must have been latched on the start.
    base_addr = 32'hDEAD_BEE0; num_rows = 16'd7; num_cols = 16'd9; row_stride = 16'h1234; col_stride = 16'h0004;
`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
    pad_cols = 16'd3;
`else
    if (pad != '0) check("pad_arg_unused", DW'(pad), 0);
`endif
  endtask

  task automatic wait_done(input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) break;
      @(negedge clk_i);
    end
    check({tag, "_done_seen"}, DW'(done_cnt), 1);
    @(negedge clk_i);
    #3;
    check({tag, "_done_once"}, DW'(done_cnt), 1);
    check({tag, "_idle_after"}, DW'(busy_o), 0);
    check({tag, "_addr_left"}, DW'(exp_addr.size()), 0);
    check({tag, "_data_left"}, DW'(exp_data.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv0, v0;
    rst_i = 1'b1; start_i = 1'b0;
    base_addr = '0; num_rows = '0; num_cols = '0; row_stride = '0; col_stride = '0;
`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
    pad_cols = '0;
`endif
    repeat (3) @(negedge clk_i);
    #3;
    check("rst_busy", DW'(busy_o), 0);
    check("rst_done", DW'(done_o), 0);
    check("rst_req", DW'(bus.mem_req), 0);
    check("rst_addr", DW'(bus.mem_addr), 0);
    check("rst_valid", DW'(bus.valid), 0);
    check("rst_data", bus.data, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Basic tile: latency, throughput and done timing.
    run_tile(32'h100, 16'd2, 16'd3, 16'h40, 16'h10, 16'd0);
    check("t1_busy", DW'(busy_o), 1);
    wait_done(200, "t1");
    check("t1_grants", DW'(n_grant), 6);
    check("t1_vectors", DW'(n_hs), 6);
    check("t1_first_latency", DW'(first_vld_cyc - first_gnt_cyc), 2);
    check("t1_throughput", DW'(last_hs_cyc - first_vld_cyc), 5);
    check("t1_done_gap", DW'(done_cyc - last_hs_cyc), 1);

    // Backpressure, plus a start pulse while busy that must be ignored.
    rdy_en = 1'b0;
    run_tile(32'h100, 16'd2, 16'd3, 16'h40, 16'h10, 16'd0);
    for (int i = 0; i < 20; i++) begin
      if (i == 3) begin
        base_addr = 32'h0000_9990; num_rows = 16'd1; num_cols = 16'd1; start_i = 1'b1;
      end else begin
        start_i = 1'b0;
      end
      @(negedge clk_i);
    end
    #3;
    check("t2_grants_capped", DW'(n_grant), DEPTH);
    check("t2_req_low", DW'(bus.mem_req), 0);
    check("t2_valid_high", DW'(bus.valid), 1);
    check("t2_no_handshake", DW'(n_hs), 0);
    rdy_en = 1'b1;
    wait_done(200, "t2");
    check("t2_vectors", DW'(n_hs), 6);

    // Memory stall after two grants: request and address must hold.
    run_tile(32'h100, 16'd2, 16'd3, 16'h40, 16'h10, 16'd0);
    for (int i = 0; i < 50; i++) begin
      if (n_grant >= 2) break;
      @(negedge clk_i);
    end
    check("t3_two_grants", DW'(n_grant), 2);
    gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      check("t3_req_hold", DW'(bus.mem_req), 1);
      check("t3_addr_hold", DW'(bus.mem_addr), DW'(32'h120));
      @(negedge clk_i);
    end
    gnt_en = 1'b1;
    wait_done(200, "t3");
    check("t3_grants", DW'(n_grant), 6);

    // Empty tile: straight to FIN, no memory traffic.
    run_tile(32'h300, 16'd0, 16'd5, 16'h40, 16'h10, 16'd0);
    #3;
    check("t4_busy", DW'(busy_o), 1);
    check("t4_done", DW'(done_o), 1);
    check("t4_req", DW'(bus.mem_req), 0);
    @(negedge clk_i);
    #3;
    check("t4_busy_end", DW'(busy_o), 0);
    check("t4_done_end", DW'(done_o), 0);
    check("t4_grants", DW'(n_grant), 0);
    check("t4_done_count", DW'(done_cnt), 1);

    // Reset mid-transfer with late responses still in flight.
    lat = 4;
    run_tile(32'h100, 16'd2, 16'd3, 16'h40, 16'h10, 16'd0);
    for (int i = 0; i < 50; i++) begin
      if (n_grant >= 3) break;
      @(negedge clk_i);
    end
    check("t5_three_grants", DW'(n_grant), 3);
    rst_i = 1'b1;
    rv0 = n_rvalid;
    v0 = n_vld;
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (8) @(negedge clk_i);
    #3;
    check("t5_late_rvalids", DW'(n_rvalid - rv0 >= 2), 1);
    check("t5_valid_stayed_low", DW'(n_vld - v0), 0);
    check("t5_no_done", DW'(done_cnt), 0);
    check("t5_idle", DW'(busy_o), 0);
    check("t5_rsp_drained", DW'(rsp_q.size()), 0);
    lat = 1;
    run_tile(32'h100, 16'd2, 16'd3, 16'h40, 16'h10, 16'd0);
    wait_done(200, "t5");
    check("t5_vectors", DW'(n_hs), 6);

    // Address wrap-around modulo 2^AW, with a slower memory.
    lat = 2;
    run_tile(32'hFFFF_FFF0, 16'd2, 16'd3, 16'h8000, 16'h10, 16'd0);
    wait_done(200, "t6");
    check("t6_vectors", DW'(n_hs), 6);
    lat = 1;

`ifdef ITA_TILE_STREAMER_ZERO_PAD_EN
    run_tile(32'h200, 16'd2, 16'd2, 16'h40, 16'h10, 16'd1);
    wait_done(200, "t7");
    check("t7_grants", DW'(n_grant), 4);
    check("t7_vectors", DW'(n_hs), 6);
    run_tile(32'h200, 16'd1, 16'd0, 16'h40, 16'h10, 16'd2);
    wait_done(200, "t8");
    check("t8_grants", DW'(n_grant), 0);
    check("t8_vectors", DW'(n_hs), 2);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
